// File: rtl/rv_pkg.sv
// Shared encodings for the RISC-V integer ALU pipeline: opcodes, funct fields
// and the internal ALU operation set.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 value (bit 5 set) that turns ADD into SUB and SRL into SRA
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam int         F7_ALT_BIT = 5;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; shifts use only the low log2(XLEN) bits of b.
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e           alu_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (alu_op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/rv_alu_pipe.sv
// Two-stage OP/OP-IMM decode/execute pipeline with internal register file,
// forwarding from stage D and a backpressured result register.
module rv_alu_pipe
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int IW = $clog2(NREG);
  localparam bit WIDE = (XLEN == 64);

  logic [XLEN-1:0] regs [NREG];

  logic            d_valid, d_illegal;
  alu_op_e         d_op;
  logic [XLEN-1:0] d_a, d_b;
  logic [4:0]      d_rd;

  logic [XLEN-1:0] alu_y;
  logic            stall;

  logic [6:0]      opcode, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic    dec_ok, use_imm, legal, shamt_ok;
  alu_op_e dec_op;

  // A shift immediate wider than 31 only exists on the 64-bit datapath.
  assign shamt_ok = WIDE || !instr[25];

  always_comb begin
    dec_ok  = 1'b0;
    dec_op  = ALU_ADD;
    use_imm = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          dec_ok = 1'b1;
          dec_op = base_op(f3);
        end else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) begin
          dec_ok = 1'b1;
          dec_op = (f3 == F3_ADD) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (f3)
          F3_SLL: begin
            dec_ok = (f7[6:1] == 6'b000000) && shamt_ok;
            dec_op = ALU_SLL;
          end
          F3_SR: begin
            dec_ok = (f7[6:1] == 6'b000000 || f7[6:1] == 6'b010000) && shamt_ok;
            dec_op = f7[F7_ALT_BIT] ? ALU_SRA : ALU_SRL;
          end
          default: begin
            dec_ok = 1'b1;
            dec_op = base_op(f3);
          end
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign legal = dec_ok && (int'(rd) < NREG) && (int'(rs1) < NREG)
                 && (use_imm || (int'(rs2) < NREG));

  logic [XLEN-1:0] a_val, b_val;
  logic            fwd_a, fwd_b;

  // The legal instr in stage D writes back on this same edge, so its ALU
  // value replaces the stale register file copy.
  assign fwd_a = d_valid && !d_illegal && (d_rd != 5'd0) && (d_rd == rs1);
  assign fwd_b = d_valid && !d_illegal && (d_rd != 5'd0) && (d_rd == rs2);

  always_comb begin
    a_val = '0;
    b_val = '0;
    if (rs1 != 5'd0 && int'(rs1) < NREG) a_val = regs[rs1[IW-1:0]];
    if (rs2 != 5'd0 && int'(rs2) < NREG) b_val = regs[rs2[IW-1:0]];
    if (fwd_a) a_val = alu_y;
    if (fwd_b) b_val = alu_y;
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .alu_op (d_op),
    .a      (d_a),
    .b      (d_b),
    .y      (alu_y)
  );

  // Stage D, output register and writeback all move together unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid     <= 1'b0;
      d_illegal   <= 1'b0;
      d_op        <= ALU_ADD;
      d_a         <= '0;
      d_b         <= '0;
      d_rd        <= '0;
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (!stall) begin
      d_valid <= in_valid;
      if (in_valid) begin
        d_illegal <= !legal;
        d_op      <= dec_op;
        d_a       <= a_val;
        d_b       <= use_imm ? imm : b_val;
        d_rd      <= legal ? rd : 5'd0;
      end
      out_valid <= d_valid;
      if (d_valid) begin
        out_rd      <= d_rd;
        out_result  <= d_illegal ? '0 : alu_y;
        out_illegal <= d_illegal;
        if (!d_illegal && d_rd != 5'd0) regs[d_rd[IW-1:0]] <= alu_y;
      end
    end
  end

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Directed bench for rv_alu_pipe: a 32/32 instance carries most checks, with
// NREG=16 and XLEN=64 instances sharing the same stream for their boundaries.
module tb_rv_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_illegal;
  logic [4:0]  out_rd;
  logic [31:0] out_result;

  logic        inr16, v16, ill16;
  logic [4:0]  rd16;
  logic [31:0] res16;

  logic        inr64, v64, ill64;
  logic [4:0]  rd64;
  logic [63:0] res64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lat_en = 1'b1;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [63:0] res;
    logic        ill;
    int          acc;
    bit          lat;
    int          which;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv_alu_pipe #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_result(out_result), .out_illegal(out_illegal)
  );

  rv_alu_pipe #(.XLEN(32), .NREG(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr16),
    .instr(instr), .out_valid(v16), .out_ready(out_ready),
    .out_rd(rd16), .out_result(res16), .out_illegal(ill16)
  );

  rv_alu_pipe #(.XLEN(64), .NREG(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inr64),
    .instr(instr), .out_valid(v64), .out_ready(out_ready),
    .out_rd(rd64), .out_result(res64), .out_illegal(ill64)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc = 7'b0010011);
    return {imm, rs1, f3, rd, opc};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one instr from a negedge and holds it until the pipe takes it.
  task automatic applyStimulus(input string name, input logic [31:0] ins,
                               input logic [4:0] rd, input logic [63:0] res,
                               input logic ill, input int which = 0);
    exp_t e;
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    instr = ins;
    #2;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!in_ready) begin
      checkOutput({name, ".accept_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.name = name; e.rd = rd; e.res = res; e.ill = ill;
    e.acc = cyc + 1; e.lat = lat_en; e.which = which;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    checkOutput({name, ".drained"}, 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    logic [63:0] g_rd, g_res, g_ill;
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checkOutput("unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        case (mon_e.which)
          1: begin g_rd = 64'(rd16); g_res = 64'(res16); g_ill = 64'(ill16); end
          2: begin g_rd = 64'(rd64); g_res = res64; g_ill = 64'(ill64); end
          default: begin g_rd = 64'(out_rd); g_res = 64'(out_result); g_ill = 64'(out_illegal); end
        endcase
        checkOutput({mon_e.name, ".rd"}, g_rd, 64'(mon_e.rd));
        checkOutput({mon_e.name, ".result"}, g_res, mon_e.res);
        checkOutput({mon_e.name, ".illegal"}, g_ill, 64'(mon_e.ill));
        if (mon_e.lat) checkOutput({mon_e.name, ".latency"}, 64'(cyc - mon_e.acc), 64'd1);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst.out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst.in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst.out_rd", 64'(out_rd), 64'd0);
    checkOutput("rst.out_result", 64'(out_result), 64'd0);
    checkOutput("rst.out_illegal", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;

    applyStimulus("addi_x1_5",  enc_i(12'd5,   5'd0, 3'b000, 5'd1), 5'd1, 64'h5, 1'b0);
    applyStimulus("addi_x2_m3", enc_i(12'hFFD, 5'd0, 3'b000, 5'd2), 5'd2, 64'hFFFF_FFFD, 1'b0);
    applyStimulus("add_x3",     enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 5'd3, 64'h2, 1'b0);

    applyStimulus("dep_1", enc_i(12'd1, 5'd0, 3'b000, 5'd1), 5'd1, 64'h1, 1'b0);
    applyStimulus("dep_2", enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd1), 5'd1, 64'h2, 1'b0);
    applyStimulus("dep_4", enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd1), 5'd1, 64'h4, 1'b0);

    applyStimulus("addi_x5",  enc_i(12'd1,   5'd0, 3'b000, 5'd5), 5'd5, 64'h1, 1'b0);
    applyStimulus("slli_x5",  enc_i(12'd31,  5'd5, 3'b001, 5'd5), 5'd5, 64'h8000_0000, 1'b0);
    applyStimulus("srai",     enc_i(12'h404, 5'd5, 3'b101, 5'd6), 5'd6, 64'hF800_0000, 1'b0);
    applyStimulus("srli",     enc_i(12'h004, 5'd5, 3'b101, 5'd6), 5'd6, 64'h0800_0000, 1'b0);
    applyStimulus("slt",      enc_r(7'h00, 5'd0, 5'd5, 3'b010, 5'd7), 5'd7, 64'h1, 1'b0);
    applyStimulus("sltu",     enc_r(7'h00, 5'd0, 5'd5, 3'b011, 5'd7), 5'd7, 64'h0, 1'b0);
    applyStimulus("slli_b25", enc_i(12'h021, 5'd5, 3'b001, 5'd8), 5'd0, 64'h0, 1'b1);
    applyStimulus("sub",      enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd9),  5'd9,  64'hFFFF_FFF9, 1'b0);
    applyStimulus("xori",     enc_i(12'h00F, 5'd2, 3'b100, 5'd10), 5'd10, 64'hFFFF_FFF2, 1'b0);
    applyStimulus("ori",      enc_i(12'h030, 5'd1, 3'b110, 5'd11), 5'd11, 64'h34, 1'b0);
    applyStimulus("andi",     enc_i(12'hFF0, 5'd2, 3'b111, 5'd12), 5'd12, 64'hFFFF_FFF0, 1'b0);
    applyStimulus("slti",     enc_i(12'hFFE, 5'd2, 3'b010, 5'd13), 5'd13, 64'h1, 1'b0);
    applyStimulus("sltiu",    enc_i(12'hFFF, 5'd1, 3'b011, 5'd13), 5'd13, 64'h1, 1'b0);
    applyStimulus("slt_pos",  enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd13), 5'd13, 64'h0, 1'b0);
    applyStimulus("sltu_big", enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd13), 5'd13, 64'h0, 1'b0);
    applyStimulus("sll",      enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd14), 5'd14, 64'h40, 1'b0);
    applyStimulus("sra",      enc_r(7'h20, 5'd1, 5'd5, 3'b101, 5'd15), 5'd15, 64'hF800_0000, 1'b0);
    applyStimulus("srl_mask", enc_r(7'h00, 5'd9, 5'd2, 3'b101, 5'd16), 5'd16, 64'h7F, 1'b0);
    applyStimulus("or",       enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd17), 5'd17, 64'hFFFF_FFFD, 1'b0);
    applyStimulus("and",      enc_r(7'h00, 5'd1, 5'd2, 3'b111, 5'd18), 5'd18, 64'h4, 1'b0);
    applyStimulus("xor",      enc_r(7'h00, 5'd5, 5'd1, 3'b100, 5'd19), 5'd19, 64'h8000_0004, 1'b0);
    applyStimulus("bad_f7",   enc_r(7'h01, 5'd1, 5'd1, 3'b000, 5'd19), 5'd0, 64'h0, 1'b1);
    applyStimulus("bad_alt",  enc_r(7'h20, 5'd1, 5'd1, 3'b001, 5'd19), 5'd0, 64'h0, 1'b1);

    applyStimulus("load_op",  enc_i(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011), 5'd0, 64'h0, 1'b1);
    applyStimulus("x1_kept",  enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd20), 5'd20, 64'h4, 1'b0);
    applyStimulus("addi_x0",  enc_i(12'd7, 5'd0, 3'b000, 5'd0), 5'd0, 64'h7, 1'b0);
    applyStimulus("read_x0",  enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd21), 5'd21, 64'h0, 1'b0);

    applyStimulus("n16_rd20", enc_i(12'd1, 5'd0, 3'b000, 5'd20), 5'd0, 64'h0, 1'b1, 1);
    applyStimulus("n16_rs17", enc_r(7'h00, 5'd0, 5'd17, 3'b000, 5'd3), 5'd0, 64'h0, 1'b1, 1);
    applyStimulus("n16_ok",   enc_i(12'd9, 5'd0, 3'b000, 5'd3), 5'd3, 64'h9, 1'b0, 1);
    idle();
    drain("main");

    // Backpressure: three instrs offered while the consumer refuses for a while.
    @(negedge clk);
    out_ready = 1'b0;
    lat_en = 1'b0;
    fork
      begin
        applyStimulus("bp_a", enc_i(12'd11, 5'd0, 3'b000, 5'd22), 5'd22, 64'd11, 1'b0);
        applyStimulus("bp_b", enc_i(12'd22, 5'd0, 3'b000, 5'd23), 5'd23, 64'd22, 1'b0);
        applyStimulus("bp_c", enc_i(12'd33, 5'd0, 3'b000, 5'd24), 5'd24, 64'd33, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        checkOutput("bp.in_ready_low", 64'(in_ready), 64'd0);
        checkOutput("bp.out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp.hold1", 64'(out_result), 64'd11);
        @(negedge clk);
        #1;
        checkOutput("bp.hold2", 64'(out_result), 64'd11);
        checkOutput("bp.hold_rd", 64'(out_rd), 64'd22);
        out_ready = 1'b1;
      end
    join
    lat_en = 1'b1;
    applyStimulus("bp_sum", enc_r(7'h00, 5'd24, 5'd22, 3'b000, 5'd25), 5'd25, 64'd44, 1'b0);

    applyStimulus("w64_m1",   enc_i(12'hFFF, 5'd0, 3'b000, 5'd1), 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
    applyStimulus("w64_srli", enc_i(12'h03F, 5'd1, 3'b101, 5'd2), 5'd2, 64'h1, 1'b0, 2);
    applyStimulus("w64_slli", enc_i(12'h020, 5'd1, 3'b001, 5'd3), 5'd3, 64'hFFFF_FFFF_0000_0000, 1'b0, 2);
    idle();
    drain("w64");

    // Reset while one instr sits in the output register and one in stage D.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = enc_i(12'd9, 5'd0, 3'b000, 5'd1);
    @(negedge clk);
    instr = enc_i(12'd8, 5'd0, 3'b000, 5'd2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("mid.pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid.out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid.out_result", 64'(out_result), 64'd0);
    checkOutput("mid.in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid.v64", 64'(v64), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid.idle_valid", 64'(out_valid), 64'd0);

    for (int r = 1; r < 13; r++)
      applyStimulus($sformatf("zero_x%0d", r), enc_r(7'h00, 5'd0, 5'(r), 3'b000, 5'(r)),
                    5'(r), 64'h0, 1'b0);
    idle();
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
